// File: rtl/result_drain_streamer_if.sv
// Handshake/bus bundle for result_drain_streamer: control, results-SRAM read port, output element stream.
// master = streamer side, slave = controller/SRAM/sink side.
interface result_drain_streamer_if #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 16
);
    logic                                  start;
    logic [ADDRESSSIZE-1:0]                base_addr;
    logic                                  sram_rd_en;
    logic [ADDRESSSIZE-1:0]                sram_address;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_in;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [PARTIAL_SUM_BW-1:0]             out_data;
    logic                                  out_last;
    logic                                  busy;
    logic                                  done;

    modport master (
        input  start, base_addr, sram_data_in, out_ready,
        output sram_rd_en, sram_address, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, base_addr, sram_data_in, out_ready,
        input  sram_rd_en, sram_address, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/result_drain_streamer.sv
// Purpose: reads NUM_ROWS result rows from SRAM and streams them one PARTIAL_SUM_BW element per beat.
// Latency: first out_valid 3 cycles after start; 2 bubbles per row, none with RESULT_DRAIN_PREFETCH_EN.
// Backpressure: valid/ready; element and out_last held stable while out_ready is low.
module result_drain_streamer #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 16,
    parameter int NUM_ROWS       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    result_drain_streamer_if.master   bus
);
    localparam int KW = $clog2(MATRIX_SIZE);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int WW = PARTIAL_SUM_BW * MATRIX_SIZE;

    typedef enum logic [1:0] {IDLE, READ, WAIT, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] row_ptr_q, row_ptr_d;
    logic [RW-1:0]          row_q, row_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WW-1:0]          word_q, word_d;
    logic                   done_q, done_d;
    logic                   hs;
    logic                   last_elem;
    logic                   last_row;

`ifdef RESULT_DRAIN_PREFETCH_EN
    logic [WW-1:0]          pf_word_q;
    logic                   pf_cap_q;
    logic                   row_entry_q;
    logic                   pf_rd;
`endif

    assign last_elem = (k_q == KW'(MATRIX_SIZE - 1));
    assign last_row  = (row_q == RW'(NUM_ROWS - 1));
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;

    always_comb begin
        state_d          = state_q;
        row_ptr_d        = row_ptr_q;
        row_d            = row_q;
        k_d              = k_q;
        word_d           = word_q;
        done_d           = 1'b0;
        hs               = 1'b0;
        bus.sram_rd_en   = 1'b0;
        bus.sram_address = '0;
        bus.out_valid    = 1'b0;
        bus.out_data     = '0;
        bus.out_last     = 1'b0;
`ifdef RESULT_DRAIN_PREFETCH_EN
        pf_rd            = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_ptr_d = bus.base_addr;
                    row_d     = '0;
                    k_d       = '0;
                    state_d   = READ;
                end
            end
            READ: begin
                bus.sram_rd_en   = 1'b1;
                bus.sram_address = row_ptr_q;
                state_d          = WAIT;
            end
            WAIT: begin
                word_d  = bus.sram_data_in;
                state_d = SHIFT;
            end
            SHIFT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = word_q[k_q*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
                bus.out_last  = last_row & last_elem;
                hs            = bus.out_ready;
`ifdef RESULT_DRAIN_PREFETCH_EN
                // Fetch the next row while the current one is still streaming out.
                if (row_entry_q && !last_row) begin
                    pf_rd            = 1'b1;
                    bus.sram_rd_en   = 1'b1;
                    bus.sram_address = row_ptr_q + ADDRESSSIZE'(1);
                end
`endif
                if (hs) begin
                    if (!last_elem) begin
                        k_d = k_q + KW'(1);
                    end else begin
                        k_d = '0;
                        if (!last_row) begin
                            row_ptr_d = row_ptr_q + ADDRESSSIZE'(1);
                            row_d     = row_q + RW'(1);
`ifdef RESULT_DRAIN_PREFETCH_EN
                            // With a 2-element row the prefetch may land in this very cycle.
                            word_d    = pf_cap_q ? bus.sram_data_in : pf_word_q;
`else
                            state_d   = READ;
`endif
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_ptr_q <= '0;
            row_q     <= '0;
            k_q       <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_ptr_q <= row_ptr_d;
            row_q     <= row_d;
            k_q       <= k_d;
            word_q    <= word_d;
            done_q    <= done_d;
        end
    end

`ifdef RESULT_DRAIN_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_word_q   <= '0;
            pf_cap_q    <= 1'b0;
            row_entry_q <= 1'b0;
        end else begin
            pf_cap_q    <= pf_rd;
            row_entry_q <= (state_d == SHIFT) && ((state_q != SHIFT) || (hs && last_elem));
            if (pf_cap_q) begin
                pf_word_q <= bus.sram_data_in;
            end
        end
    end
`endif
endmodule

// File: tb/tb_result_drain_streamer.sv
// Bench for result_drain_streamer: table of drain scenarios checked against a queue-based expected stream.
module tb_result_drain_streamer;
    localparam int AW = 10;
    localparam int BW = 24;
    localparam int MS = 16;
    localparam int NR = 16;
    localparam int WW = BW * MS;
`ifdef RESULT_DRAIN_PREFETCH_EN
    localparam int LAST_HS = NR * MS + 2;
`else
    localparam int LAST_HS = NR * (MS + 2);
`endif

    typedef struct {
        int base;
        int pat;       // 0: row*MS+k, 1: random with extreme first/last elements
        int rmode;     // 0: ready=1, 1: ready 1-of-3, 2: random
        int mid_beat;  // beat at which a stray start is pulsed (-1 none)
        int alt_base;
        int rst_beat;  // beat after which rst is pulsed (-1 none)
        int timing;    // check exact cycle numbers
        int exp_beats;
        int exp_done;
    } case_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_drain_streamer_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(BW), .MATRIX_SIZE(MS)) bus ();

    result_drain_streamer #(
        .ADDRESSSIZE(AW), .PARTIAL_SUM_BW(BW), .MATRIX_SIZE(MS), .NUM_ROWS(NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic          rd_pend;
    logic [AW-1:0] rd_addr;
    int            c;
    int            vectors;
    int            miscompares;
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    case_t         cases[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, c, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One cycle: SRAM model answers last cycle's read, garbage otherwise.
    task automatic tick();
        @(negedge clk);
        c++;
        bus.sram_data_in = rd_pend ? mem[rd_addr] : rand_word();
        rd_pend = bus.sram_rd_en;
        rd_addr = bus.sram_address;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   64'(bus.sram_rd_en), 64'd0);
        check({tag, "_address"}, 64'(bus.sram_address), 64'd0);
        check({tag, "_valid"},   64'(bus.out_valid), 64'd0);
        check({tag, "_data"},    64'(bus.out_data), 64'd0);
        check({tag, "_last"},    64'(bus.out_last), 64'd0);
        check({tag, "_busy"},    64'(bus.busy), 64'd0);
        check({tag, "_done"},    64'(bus.done), 64'd0);
    endtask

    task automatic run_case(input case_t tc);
        int c0, rc, beats, done_cnt, first_v, last_hs;
        bit prev_stall, prev_last, finished, mid_sent, hs;
        logic [BW-1:0] prev_data, e;

        for (int a = 0; a < (1 << AW); a++) mem[a] = rand_word();
        exp_q.delete();
        addr_q.delete();
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < MS; k++) begin
                if (tc.pat == 0) e = BW'(r * MS + k);
                else if (k == 0) e = 24'hFFFFFF;
                else if (k == MS - 1) e = 24'h800000;
                else e = BW'($urandom);
                mem[AW'(tc.base + r)][k*BW +: BW] = e;
                exp_q.push_back(e);
            end
            addr_q.push_back(AW'(tc.base + r));
        end

        check("busy_before_start", 64'(bus.busy), 64'd0);
        bus.start = 1'b1;
        bus.base_addr = AW'(tc.base);
        c0 = c;
        beats = 0; done_cnt = 0; first_v = -1; last_hs = -1;
        prev_stall = 0; prev_last = 0; prev_data = '0; finished = 0; mid_sent = 0;

        for (int i = 0; i < 3000 && !finished; i++) begin
            tick();
            rc = c - c0;
            bus.start = 1'b0;
            if (bus.sram_rd_en) begin
                if (addr_q.size() == 0) check("extra_sram_read", 64'(bus.sram_address), 64'hFFFF);
                else check("sram_address", 64'(bus.sram_address), 64'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                check("stall_valid_held", 64'(bus.out_valid), 64'd1);
                check("stall_data_held", 64'(bus.out_data), 64'(prev_data));
                check("stall_last_held", 64'(bus.out_last), 64'(prev_last));
            end
            if (bus.done) begin
                done_cnt++;
                check("done_after_last_hs", 64'(rc), 64'(last_hs + 1));
                check("busy_low_at_done", 64'(bus.busy), 64'd0);
                check("beats_at_done", 64'(beats), 64'(NR * MS));
            end
            if (rc == 1) check("busy_after_start", 64'(bus.busy), 64'd1);
            if (bus.out_valid && first_v < 0) first_v = rc;

            case (tc.rmode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = (rc % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (tc.mid_beat >= 0 && !mid_sent && beats == tc.mid_beat && bus.out_valid) begin
                bus.start = 1'b1;
                bus.base_addr = AW'(tc.alt_base);
                mid_sent = 1;
            end

            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(bus.out_data), 64'hFFFF_FFFF);
                end else begin
                    check("out_last", 64'(bus.out_last), 64'(exp_q.size() == 1));
                    check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                end
                beats++;
                last_hs = rc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_last = bus.out_last;

            if (tc.rst_beat >= 0 && hs && beats == tc.rst_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                bus.out_ready = 1'b1;
                check_reset_outputs("after_midrun_rst");
                for (int j = 0; j < 6; j++) begin
                    tick();
                    check("no_done_after_rst", 64'(bus.done), 64'd0);
                    check("idle_after_rst", 64'(bus.out_valid), 64'd0);
                end
                break;
            end
            if (done_cnt > 0 && rc > last_hs + 3) finished = 1;
        end

        check("done_pulses", 64'(done_cnt), 64'(tc.exp_done));
        check("beats_total", 64'(beats), 64'(tc.exp_beats));
        if (tc.exp_done == 1) check("all_rows_read", 64'(addr_q.size()), 64'd0);
        if (tc.timing != 0) begin
            check("first_valid_cycle", 64'(first_v), 64'd3);
            check("last_hs_cycle", 64'(last_hs), 64'(LAST_HS));
        end
        bus.out_ready = 1'b0;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        c = 0;
        rd_pend = 1'b0;
        rd_addr = '0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.out_ready = 1'b0;
        bus.sram_data_in = '0;

        //          base  pat rm mid alt  rst  tim beats done
        cases[0] = '{0,    0, 0, -1, 0,   -1,  1,  256,  1};
        cases[1] = '{0,    0, 1, -1, 0,   -1,  0,  256,  1};
        cases[2] = '{1020, 1, 0, -1, 0,   -1,  1,  256,  1};
        cases[3] = '{0,    0, 0, 40, 500, -1,  1,  256,  1};
        cases[4] = '{0,    0, 2, -1, 0,   100, 0,  100,  0};
        cases[5] = '{0,    0, 0, -1, 0,   -1,  1,  256,  1};
        cases[6] = '{777,  1, 2, -1, 0,   -1,  0,  256,  1};

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("idle");

        for (int t = 0; t < 7; t++) run_case(cases[t]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/result_drain_streamer.md
# result_drain_streamer

Read-side counterpart of the systolic array's result write path: after a matrix multiply has deposited MATRIX_SIZE-wide rows of partial sums into the results SRAM, this block reads those rows back and serializes them, one PARTIAL_SUM_BW element per beat, onto a valid/ready stream toward the host or output interface. It owns the results-SRAM read port, sequences row addresses from a latched base address, and signals completion with a single-cycle `done` pulse.

## Interface
- ADDRESSSIZE, 10, results-SRAM address width
- PARTIAL_SUM_BW, 24, element width (signed partial sum)
- MATRIX_SIZE, 16, elements per SRAM row (≥2)
- NUM_ROWS, 16, rows drained per start (≥1)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a drain; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first row address, latched with start
- sram_rd_en  out  1  read strobe to results SRAM
- sram_address  out  ADDRESSSIZE  row address
- sram_data_in  in  PARTIAL_SUM_BW*MATRIX_SIZE  read data, valid the cycle after sram_rd_en
- out_valid  out  1  stream element valid
- out_ready  in  1  downstream accept
- out_data  out  PARTIAL_SUM_BW  current element
- out_last  out  1  high with final element of the drain
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after final handshake

## Operation
- States: IDLE, READ, WAIT, SHIFT.
- IDLE: start=1 latches base_addr into row pointer, clears row/element counters -> READ. start while not IDLE ignored.
- READ: sram_rd_en=1, sram_address=row pointer -> WAIT.
- WAIT: capture sram_data_in into shift register -> SHIFT.
- SHIFT: out_valid=1, out_data = word[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], k=0 first. Handshake = out_valid & out_ready; each handshake increments k.
- Handshake at k=MATRIX_SIZE-1: if row < NUM_ROWS-1, increment row pointer (mod 2^ADDRESSSIZE, wraps 2^ADDRESSSIZE-1 -> 0) -> READ; else -> IDLE with done=1 next cycle.
- out_last = out_valid & (row==NUM_ROWS-1) & (k==MATRIX_SIZE-1).
- out_data and out_last held stable while out_valid & !out_ready; out_valid never drops without a handshake.
- Data passed bit-exact; no sign extension or truncation.
- rst=1 in any state: IDLE next cycle, drain abandoned, no done pulse.

## Timing
- Reset values: sram_rd_en=0, sram_address=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- start accepted cycle 0 -> sram_rd_en cycle 1 -> first out_valid cycle 3.
- Row turnaround (no prefetch): 2 bubble cycles between last element of row r and first of r+1.
- With out_ready held 1: drain completes in NUM_ROWS*(MATRIX_SIZE+2)+1 cycles from start; done asserted the cycle after final handshake; busy falls same cycle done rises.
- Back-to-back: start may be accepted in the cycle done is high (state IDLE).
- SRAM read latency fixed at 1 cycle; sram_data_in ignored outside WAIT (and prefetch capture cycle).

## Configuration
- RESULT_DRAIN_PREFETCH_EN defined: adds a row prefetch register. On entry to SHIFT for row r (r < NUM_ROWS-1), issue read of row r+1 the same cycle and capture it the next cycle; on final handshake of row r, load shift register from prefetch and stay in SHIFT. No inter-row bubbles; with out_ready=1 drain takes NUM_ROWS*MATRIX_SIZE+2 cycles from start to last handshake.
- Undefined: no prefetch register; READ/WAIT per row as above, 2 bubbles per row.

## Test plan
- Rows at base 0 hold element value row*16+k, base_addr=0, out_ready=1 -> 256 beats in order 0..255, first out_valid cycle 3, out_last only on beat 255, done once; last handshake cycle 288 (no prefetch) / 258 (prefetch).
- Same data, out_ready toggling 1-of-3 cycles -> identical sequence, out_data stable across every stall, no lost/duplicate beats.
- base_addr=1020 -> sram_address sequence 1020..1023,0..11; data matches those rows.
- Element 0 = 24'hFFFFFF, element 15 = 24'h800000 -> emitted unchanged.
- start pulsed mid-drain at beat 40 -> ignored, base_addr change not applied, 256 beats total.
- rst asserted at beat 100 for one cycle -> next cycle all outputs at reset values, no done; fresh start then drains full 256 beats.
